// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (port 0) and loader/debug (port 1) share one
// single-cycle memory, with round-robin tie-breaking and a bounded burst under contention.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_wr_en,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WORD_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [WORD_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr_en,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WORD_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [WORD_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [WORD_WIDTH-1:0] dmem_data_in,
  output logic                  dmem_wr_en,
  input  logic [WORD_WIDTH-1:0] dmem_data_out
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_t        state;
  logic          last_owner;
  logic [CW-1:0] beat_cnt;

  // NOTE: grants are gated by rst so a reset landing mid-burst can never strobe a write.
  always_comb begin
    m0_gnt       = ~rst & (state == OWN0) & m0_req;
    m1_gnt       = ~rst & (state == OWN1) & m1_req;
    dmem_addr    = '0;
    dmem_data_in = '0;
    dmem_wr_en   = 1'b0;
    if (m0_gnt) begin
      dmem_addr    = m0_addr;
      dmem_data_in = m0_wdata;
      dmem_wr_en   = m0_wr_en;
    end else if (m1_gnt) begin
      dmem_addr    = m1_addr;
      dmem_data_in = m1_wdata;
      dmem_wr_en   = m1_wr_en;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_wr_en;
      m1_rvalid <= m1_gnt & ~m1_wr_en;
      if (m0_gnt && !m0_wr_en) m0_rdata <= dmem_data_out;
      if (m1_gnt && !m1_wr_en) m1_rdata <= dmem_data_out;

      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (m0_req && (!m1_req || last_owner)) begin
            state      <= OWN0;
            last_owner <= 1'b0;
          end else if (m1_req) begin
            state      <= OWN1;
            last_owner <= 1'b1;
          end
        end
        OWN0: begin
          if (m0_req) begin
            if (m1_req && beat_cnt == LAST_BEAT) begin
              state      <= OWN1;
              last_owner <= 1'b1;
              beat_cnt   <= '0;
            end else if (beat_cnt != LAST_BEAT) begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end else begin
            beat_cnt <= '0;
            if (m1_req) begin
              state      <= OWN1;
              last_owner <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        OWN1: begin
          if (m1_req) begin
            if (m0_req && beat_cnt == LAST_BEAT) begin
              state      <= OWN0;
              last_owner <= 1'b0;
              beat_cnt   <= '0;
            end else if (beat_cnt != LAST_BEAT) begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end else begin
            beat_cnt <= '0;
            if (m0_req) begin
              state      <= OWN0;
              last_owner <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the byte-address width of every port.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 32, the data width of every port.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, the maximum number of consecutive granted beats one owner may take while the other port is requesting.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous active-high reset
- m0_req  in  1  port 0 (core) access request
- m0_wr_en  in  1  port 0 write (1) / read (0)
- m0_addr  in  ADDR_WIDTH  port 0 address
- m0_wdata  in  WORD_WIDTH  port 0 write data
- m0_gnt  out  1  port 0 beat accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  WORD_WIDTH  port 0 read data
- m1_req, m1_wr_en, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1 (loader/debug)
- dmem_addr  out  ADDR_WIDTH  to data memory
- dmem_data_in  out  WORD_WIDTH  write data to data memory
- dmem_wr_en  out  1  data memory write strobe (memory writes on rising clk)
- dmem_data_out  in  WORD_WIDTH  combinational read data from data memory

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1.
REQ-006 In IDLE, no gnt SHALL be asserted, and dmem_wr_en, dmem_addr and dmem_data_in SHALL all be 0.
REQ-007 From IDLE, the next state SHALL be:
- OWN0 if only m0_req is high;
- OWN1 if only m1_req is high;
- if both are high, OWN of the port opposite last_owner;
- otherwise stay in IDLE.
This gives one cycle of arbitration latency.
REQ-008 In OWNx, mx_gnt SHALL equal mx_req, and the other port's gnt SHALL be 0.
REQ-009 In OWNx with mx_gnt high, the mx_addr, mx_wdata and mx_wr_en signals SHALL drive dmem_addr, dmem_data_in and dmem_wr_en combinationally (one beat per cycle).
REQ-010 In OWNx with mx_req low, the dmem outputs SHALL be 0, and the next state SHALL be OWN of the other port if that port requests, else IDLE.
REQ-011 A beat counter SHALL count granted beats in the current ownership, and SHALL clear to 0 on every ownership change and on entry to IDLE.
REQ-012 In OWNx, if mx_req is high, beat_cnt == MAX_BURST-1 and the other port requests, then:
- the current beat SHALL still be granted;
- the next state SHALL be OWN of the other port.
REQ-013 If the other port is not requesting, the owner SHALL keep ownership beyond MAX_BURST beats, and the beat counter SHALL saturate at MAX_BURST-1.
REQ-014 last_owner SHALL update to x on every transition into OWNx.
REQ-015 On a granted read beat (gnt high, wr_en 0) by port x, in the following cycle:
- mx_rvalid SHALL be 1;
- mx_rdata SHALL hold the dmem_data_out value sampled at that edge.
REQ-016 mx_rvalid SHALL be 0 in any cycle not following a granted read by port x, and mx_rdata SHALL hold its last value.
REQ-017 Granted writes SHALL produce no rvalid.
REQ-018 Back-to-back granted reads SHALL produce back-to-back rvalid pulses with no bubble.
REQ-019 A port that drops req mid-burst and re-raises it SHALL re-arbitrate per REQ-007 or REQ-010; it SHALL NOT resume the old beat count.

Reset
REQ-020 When rst = 1 at a rising edge, the block SHALL set: state IDLE, last_owner 1 (so port 0 wins the first tie), beat_cnt 0, m0_rvalid = m1_rvalid = 0, m0_rdata = m1_rdata = 0.
REQ-021 While rst = 1, dmem_wr_en, m0_gnt and m1_gnt SHALL be forced to 0 combinationally regardless of state, so that a reset mid-burst causes no memory write.
REQ-022 After rst deasserts, the first grant SHALL occur no earlier than one cycle after a req is sampled in IDLE.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single read: reset, then m0_req = 1 with addr 0x10 and memory[0x10] = 0xDEADBEEF. Required: m0_gnt in cycle 2, m0_rvalid with m0_rdata = 0xDEADBEEF in cycle 3.
- Simultaneous first request: m0_req and m1_req rise together after reset. Required: OWN0 first; with both held, port 0 gets exactly 4 beats, then OWN1 is entered with no idle cycle between.
- Round-robin alternation: both ports request continuously for 16 cycles. Required: grants alternate in blocks of 4 beats, and neither gnt is high in the same cycle as the other.
- Uncontended long burst: m1 writes 8 words to 0x00..0x1C while m0 is idle. Required: 8 consecutive m1_gnt, memory holds all 8 words, beat counter saturates.
- Reset mid-burst: rst asserted during an m0 write burst at beat 2. Required: dmem_wr_en = 0 during the reset cycle, the target word is unchanged, both rvalid = 0, and the FSM is in IDLE afterwards.
- Owner drops req: OWN0 with m1_req high and m0_req falling after 1 beat. Required: next state OWN1, m1_gnt in the following cycle, beat count restarts at 0.
